// File: rtl/mem_loader.sv
// Program-image writer: packs a valid/ready byte stream into 16-bit words and
// writes them to consecutive RAM addresses while holding the CPU in reset.
module mem_loader #(
   parameter int unsigned AW   = 7,
   parameter int unsigned DW   = 16,
   parameter int unsigned BASE = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    len,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [7:0]    in_byte,
   output logic          in_ready,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned BW    = 8;
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HI    = 3'd1,
      S_LO    = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_len;
   logic [CW-1:0] r_wcount;
   logic [BW-1:0] r_hi;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_din;
   logic          r_err;
   logic [CW-1:0] w_eff_len;
   logic          w_abort;
   logic          w_accept;
   logic          w_last;

   // Loads longer than the RAM are clipped to one full pass of the address space.
   assign w_eff_len = (32'(len) > DEPTH) ? CW'(DEPTH) : CW'(len);
   assign w_abort   = abort && ((r_state == S_HI) || (r_state == S_LO) || (r_state == S_WRITE));
   assign w_accept  = in_valid && in_ready && !abort;
   assign w_last    = (r_wcount == (r_len - CW'(1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (len == 8'd0) ? S_DONE : S_HI;
            end
         end
         S_HI: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (w_accept) begin
               w_next = S_LO;
            end
         end
         S_LO: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (w_accept) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (w_last) begin
               w_next = S_DONE;
            end else begin
               w_next = S_HI;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      mem_wr   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         S_HI:    begin in_ready = 1'b1; busy = 1'b1; end
         S_LO:    begin in_ready = 1'b1; busy = 1'b1; end
         S_WRITE: begin mem_wr   = 1'b1; busy = 1'b1; end
         S_DONE:  begin done     = 1'b1; busy = 1'b1; end
         default: ;
      endcase
      cpu_hold = busy;
      mem_addr = r_mem_addr;
      mem_din  = r_mem_din;
      err      = r_err;
   end

   // Word assembly and address generation; abort wins over a same-cycle byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_len      <= '0;
         r_wcount   <= '0;
         r_hi       <= '0;
         r_mem_addr <= AW'(BASE);
         r_mem_din  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_abort;
         if ((r_state == S_IDLE) && start) begin
            r_len    <= w_eff_len;
            r_wcount <= '0;
         end
         if ((r_state == S_HI) && w_accept) begin
            r_hi <= in_byte;
         end
         if ((r_state == S_LO) && w_accept) begin
            r_mem_addr <= AW'(BASE) + r_wcount[AW-1:0];
            r_mem_din  <= DW'({r_hi, in_byte});
         end
         if (r_state == S_WRITE) begin
            r_wcount <= r_wcount + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: two instances (BASE 0 and 126) share one
// stimulus stream and are compared against a transaction-level image model.
module tb_mem_loader;

   localparam int AW    = 7;
   localparam int DW    = 16;
   localparam int DEPTH = 128;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] len;
   logic       abort;
   logic       in_valid;
   logic [7:0] in_byte;

   logic          in_ready [2];
   logic          mem_wr   [2];
   logic [AW-1:0] mem_addr [2];
   logic [DW-1:0] mem_din  [2];
   logic          cpu_hold [2];
   logic          busy     [2];
   logic          done     [2];
   logic          err      [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [AW+DW-1:0] obs0[$];
   logic [AW+DW-1:0] obs1[$];
   int               done_cnt    [2];
   int               err_cnt     [2];
   int               last_wr_cyc [2];
   int               done_cyc    [2];
   logic [7:0]       img [512];

   always #5 clk = ~clk;

   mem_loader #(.AW(AW), .DW(DW), .BASE(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready[0]),
      .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
      .cpu_hold(cpu_hold[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
   );

   mem_loader #(.AW(AW), .DW(DW), .BASE(126)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready[1]),
      .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
      .cpu_hold(cpu_hold[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
   );

   function automatic int base_of(input int d);
      return (d == 0) ? 0 : 126;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Continuous protocol observation, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (mem_wr[d] === 1'b1) begin
            if (d == 0) obs0.push_back({mem_addr[d], mem_din[d]});
            else        obs1.push_back({mem_addr[d], mem_din[d]});
            last_wr_cyc[d] = cyc;
            check("wr_hold", 32'(cpu_hold[d]), 32'd1);
            check("wr_rdy", 32'(in_ready[d]), 32'd0);
         end
         if (done[d] === 1'b1) begin
            done_cnt[d]++;
            done_cyc[d] = cyc;
         end
         if (err[d] === 1'b1) err_cnt[d]++;
         if (busy[d] === 1'b0) begin
            check("idle_rdy", 32'(in_ready[d]), 32'd0);
            check("idle_wr", 32'(mem_wr[d]), 32'd0);
            check("idle_hold", 32'(cpu_hold[d]), 32'd0);
         end
      end
   end

   task automatic clear_mon();
      obs0.delete();
      obs1.delete();
      for (int d = 0; d < 2; d++) begin
         done_cnt[d]    = 0;
         err_cnt[d]     = 0;
         last_wr_cyc[d] = -100;
         done_cyc[d]    = -100;
      end
   endtask

   task automatic check_reset_outputs();
      for (int d = 0; d < 2; d++) begin
         check("rst_rdy", 32'(in_ready[d]), 32'd0);
         check("rst_wr", 32'(mem_wr[d]), 32'd0);
         check("rst_addr", 32'(mem_addr[d]), 32'(base_of(d)));
         check("rst_din", 32'(mem_din[d]), 32'd0);
         check("rst_hold", 32'(cpu_hold[d]), 32'd0);
         check("rst_busy", 32'(busy[d]), 32'd0);
         check("rst_done", 32'(done[d]), 32'd0);
         check("rst_err", 32'(err[d]), 32'd0);
      end
   endtask

   task automatic do_start(input int l);
      start = 1'b1;
      len   = 8'(l);
      tick();
      start = 1'b0;
      len   = 8'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int   gap;
      int   waits;
      logic ok;
      gap   = $urandom_range(0, maxgap);
      waits = 0;
      ok    = 1'b0;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_byte  = 8'($urandom);
         @(negedge clk);
         if (g > 0) check("gap_rdy", 32'(in_ready[0]), 32'd1);
         tick();
      end
      in_valid = 1'b1;
      in_byte  = b;
      while (!ok && waits < 8) begin
         @(negedge clk);
         ok = in_ready[0];
         tick();
         waits++;
      end
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      check("hs_wait", 32'(ok && (waits <= 2)), 32'd1);
   endtask

   // mode: 0 normal, 1 abort in HI, 2 abort in LO (byte offered too),
   // 3 abort in WRITE, 4 reset in WRITE, 5 start pulse while busy.
   task automatic run_load(input int l, input int mode, input int k, input int maxgap, input bit keep);
      int               eff;
      int               n_exp;
      int               exp_done;
      int               exp_err;
      int               wd;
      int               sz;
      logic [AW+DW-1:0] exp_w;
      logic [AW+DW-1:0] got_w;
      eff = (l > DEPTH) ? DEPTH : l;
      if (!keep) for (int i = 0; i < 2 * eff; i++) img[i] = 8'($urandom);
      clear_mon();
      do_start(l);
      for (int w = 0; w < eff; w++) begin
         if (mode == 1 && w == k) begin
            if (w > 0) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            break;
         end
         send_byte(img[2*w], maxgap);
         if (mode == 2 && w == k) begin
            abort    = 1'b1;
            in_valid = 1'b1;
            in_byte  = img[2*w+1];
            tick();
            abort    = 1'b0;
            in_valid = 1'b0;
            break;
         end
         send_byte(img[2*w+1], maxgap);
         if (mode == 3 && w == k) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            break;
         end
         if (mode == 4 && w == k) begin
            #1 reset = 1'b0;
            #1 check_reset_outputs();
            #1 reset = 1'b1;
            tick();
            break;
         end
         if (mode == 5 && w == 0) begin
            start = 1'b1;
            len   = 8'($urandom_range(1, 255));
            tick();
            start = 1'b0;
         end
      end
      wd = 0;
      while (busy[0] && wd < 20) begin
         tick();
         wd++;
      end
      check("idle_timeout", 32'(busy[0]), 32'd0);
      tick();
      tick();

      case (mode)
         1, 2:    begin n_exp = k;     exp_done = 0; exp_err = 1; end
         3:       begin n_exp = k + 1; exp_done = 0; exp_err = 1; end
         4:       begin n_exp = k;     exp_done = 0; exp_err = 0; end
         default: begin n_exp = eff;   exp_done = 1; exp_err = 0; end
      endcase

      for (int d = 0; d < 2; d++) begin
         sz = (d == 0) ? obs0.size() : obs1.size();
         check("n_writes", 32'(sz), 32'(n_exp));
         check("n_done", 32'(done_cnt[d]), 32'(exp_done));
         check("n_err", 32'(err_cnt[d]), 32'(exp_err));
         if (exp_done == 1 && eff > 0)
            check("done_lat", 32'(done_cyc[d] - last_wr_cyc[d]), 32'd1);
         for (int i = 0; i < n_exp && i < sz; i++) begin
            exp_w = {AW'((base_of(d) + i) % DEPTH), img[2*i], img[2*i+1]};
            got_w = (d == 0) ? obs0[i] : obs1[i];
            check("wr_word", 32'(got_w), 32'(exp_w));
         end
      end
   endtask

   initial begin
      int l;
      int eff;
      int mode;
      int k;
      reset    = 1'b0;
      start    = 1'b0;
      len      = 8'd0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'd0;
      clear_mon();
      #12;
      check_reset_outputs();
      reset = 1'b1;
      tick();

      // Two back-to-back words with a known image.
      img[0] = 8'h80; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h01;
      run_load(2, 0, 0, 0, 1'b1);

      // Single word with input gaps.
      run_load(1, 0, 0, 3, 1'b0);

      // Zero-length load: one busy cycle carrying the done pulse.
      start = 1'b1;
      len   = 8'd0;
      @(negedge clk);
      check("l0_busy_pre", 32'(busy[0]), 32'd0);
      tick();
      start = 1'b0;
      @(negedge clk);
      check("l0_busy", 32'(busy[0]), 32'd1);
      check("l0_done", 32'(done[0]), 32'd1);
      check("l0_wr", 32'(mem_wr[0]), 32'd0);
      @(negedge clk);
      check("l0_busy_post", 32'(busy[0]), 32'd0);
      check("l0_done_post", 32'(done[0]), 32'd0);
      tick();
      run_load(0, 0, 0, 0, 1'b0);

      // Oversized load clips to the RAM depth; BASE=126 instance wraps.
      run_load(200, 0, 0, 0, 1'b0);

      // Abort during LO of the third word, then a normal single-word load.
      run_load(5, 2, 2, 1, 1'b0);
      run_load(1, 0, 0, 1, 1'b0);

      // Reset mid-WRITE, start while busy, abort in HI and in WRITE.
      run_load(4, 4, 1, 1, 1'b0);
      run_load(3, 5, 0, 1, 1'b0);
      run_load(3, 1, 1, 1, 1'b0);
      run_load(3, 3, 2, 1, 1'b0);

      for (int it = 0; it < 30; it++) begin
         l    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
         eff  = (l > DEPTH) ? DEPTH : l;
         mode = (eff == 0) ? 0 : $urandom_range(0, 5);
         k    = (eff == 0) ? 0 : $urandom_range(0, eff - 1);
         run_load(l, mode, k, $urandom_range(0, 3), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
